// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply exponentiation sequencer in the Montgomery domain.
// Drives one external Montgomery product unit through a four-phase start/stop handshake.
module mod_exp_ctrl #(
    parameter int bitLen     = 64,
    parameter int countWidth = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [bitLen-1:0] msg,
    input  logic [bitLen-1:0] exp,
    input  logic [bitLen-1:0] modulus,
    input  logic [bitLen-1:0] r2modn,
    output logic              busy,
    output logic              done,
    output logic [bitLen-1:0] result,
    output logic              mp_start,
    output logic [bitLen-1:0] mp_A,
    output logic [bitLen-1:0] mp_B,
    output logic [bitLen-1:0] mp_M,
    input  logic              mp_stop,
    input  logic [bitLen-1:0] mp_P
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_STOP,
        RELEASE
    } state_t;

    typedef enum logic [2:0] {
        OP_XBAR,
        OP_ABAR,
        OP_SQR,
        OP_MUL,
        OP_POST
    } op_t;

    localparam logic [countWidth-1:0] LAST_IDX = countWidth'(bitLen - 1);
    localparam logic [countWidth-1:0] IDX_ONE  = countWidth'(1);
    localparam logic [bitLen-1:0]     ONE      = bitLen'(1);

    state_t                state;
    op_t                   op;
    logic [countWidth-1:0] idx;
    logic [bitLen-1:0]     msg_r;
    logic [bitLen-1:0]     exp_r;
    logic [bitLen-1:0]     r2_r;
    logic [bitLen-1:0]     xb;
    logic [bitLen-1:0]     acc;
    logic [bitLen-1:0]     opnd_a;
    logic [bitLen-1:0]     opnd_b;

    // Operand selection for the operation about to be issued.
    always_comb begin
        opnd_a = acc;
        opnd_b = acc;
        unique case (op)
            OP_XBAR: begin
                opnd_a = msg_r;
                opnd_b = r2_r;
            end
            OP_ABAR: begin
                opnd_a = ONE;
                opnd_b = r2_r;
            end
            OP_SQR: begin
                opnd_a = acc;
                opnd_b = acc;
            end
            OP_MUL: begin
                opnd_a = acc;
                opnd_b = xb;
            end
            OP_POST: begin
                opnd_a = acc;
                opnd_b = ONE;
            end
            default: begin
                opnd_a = acc;
                opnd_b = acc;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            op       <= OP_XBAR;
            idx      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            mp_start <= 1'b0;
            mp_A     <= '0;
            mp_B     <= '0;
            mp_M     <= '0;
            msg_r    <= '0;
            exp_r    <= '0;
            r2_r     <= '0;
            xb       <= '0;
            acc      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        msg_r <= msg;
                        exp_r <= exp;
                        mp_M  <= modulus;
                        r2_r  <= r2modn;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        op    <= OP_XBAR;
                        idx   <= LAST_IDX;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    mp_A     <= opnd_a;
                    mp_B     <= opnd_b;
                    mp_start <= 1'b1;
                    state    <= WAIT_STOP;
                end
                WAIT_STOP: begin
                    if (mp_stop) begin
                        mp_start <= 1'b0;
                        if (op == OP_XBAR) begin
                            xb <= mp_P;
                        end else begin
                            acc <= mp_P;
                        end
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    // Advance only once the product unit has dropped stop.
                    if (!mp_stop) begin
                        state <= ISSUE;
                        unique case (op)
                            OP_XBAR: op <= OP_ABAR;
                            OP_ABAR: begin
                                op  <= OP_SQR;
                                idx <= LAST_IDX;
                            end
                            OP_SQR: begin
                                if (exp_r[idx]) begin
                                    op <= OP_MUL;
                                end else if (idx == '0) begin
                                    op <= OP_POST;
                                end else begin
                                    idx <= idx - IDX_ONE;
                                end
                            end
                            OP_MUL: begin
                                if (idx == '0) begin
                                    op <= OP_POST;
                                end else begin
                                    op  <= OP_SQR;
                                    idx <= idx - IDX_ONE;
                                end
                            end
                            OP_POST: begin
                                result <= acc;
                                done   <= 1'b1;
                                busy   <= 1'b0;
                                state  <= IDLE;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
